input_vc_controller: RTL and testbench

- Per-VC input controller for one router input port.
- Buffers incoming flits in a small FIFO and presents the head flit's destination to the routing computation stage.
- Latches the candidate output port/VC returned by routing computation, then arbitrates for an output VC (VA) and drives switch-allocation requests (SA).
- Returns one credit upstream per flit dequeued. One instance per input VC; the port wrapper instantiates `V of them.

---
 rtl/input_vc_controller_pkg.sv | 32 +++
 rtl/input_vc_controller_fifo.sv | 60 ++++++
 rtl/input_vc_controller.sv | 160 ++++++++++++++++
 tb/tb_input_vc_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_vc_controller_pkg.sv
// Shared types and constants for the per-VC input controller and its flit buffer.
// Flit type and controller state encodings are fixed 2-bit values seen on the wire and in debug.
package input_vc_controller_pkg;

    localparam int N          = 5;
    localparam int V          = 2;
    localparam int DEF_FLIT_W = 34;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        VC_IDLE    = 2'b00,
        VC_ROUTING = 2'b01,
        VC_VA      = 2'b10,
        VC_ACTIVE  = 2'b11
    } vc_state_e;

    function automatic logic is_head(input logic [1:0] t);
        return (t == HEAD) || (t == HEADTAIL);
    endfunction

    function automatic logic is_tail(input logic [1:0] t);
        return (t == TAIL) || (t == HEADTAIL);
    endfunction

endpackage

// File: rtl/input_vc_controller_fifo.sv
// Small circular flit buffer; front entry is read combinationally, writes are visible next cycle.
// Write and read enables are re-qualified here so a careless caller cannot corrupt the pointers.
module flit_fifo #(
    parameter int FLIT_W = 34,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wrEn,
    input  logic [FLIT_W-1:0]          wrData,
    input  logic                       rdEn,
    output logic [FLIT_W-1:0]          rdData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [FLIT_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              wr_ok_s;
    logic              rd_ok_s;

    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == {CW{1'b0}});
    assign rd_ok_s = rdEn & ~empty;
    assign wr_ok_s = wrEn & (~full | rd_ok_s);
    assign rdData  = mem_r[rd_ptr_r];
    assign count   = count_r;

    // Storage, pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {FLIT_W{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_ok_s) begin
                mem_r[wr_ptr_r] <= wrData;
                wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/input_vc_controller.sv
// Per-VC input controller: buffers flits, sequences route/VC-allocation/switch-allocation per packet,
// and returns one upstream credit for every flit that leaves the buffer.
module input_vc_controller
    import input_vc_controller_pkg::*;
#(
    parameter int CUR_X  = 0,
    parameter int CUR_Y  = 0,
    parameter int FLIT_W = DEF_FLIT_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] inFlit,
    input  logic              inValid,
    output logic              outCredit,
    output logic [7:0]        dst,
    input  logic [N-1:0]      candidateOutPort,
    input  logic [V-1:0]      candidateOutVC,
    output logic              vaReq,
    output logic [N-1:0]      vaReqPort,
    output logic [V-1:0]      vaReqVC,
    input  logic              vaGrant,
    input  logic [V-1:0]      vaGrantVC,
    input  logic              downCreditAvail,
    output logic              saReq,
    input  logic              saGrant,
    output logic [FLIT_W-1:0] outFlit,
    output logic [N-1:0]      outPort,
    output logic [V-1:0]      outVC,
    output logic              overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    // The coordinates feed the rc paired with this controller; negative values are never legal.
    if ((CUR_X < 0) || (CUR_Y < 0)) begin : g_bad_coord
    end

    vc_state_e         state_r;
    vc_state_e         next_state_s;
    logic [FLIT_W-1:0] front_s;
    logic [1:0]        front_type_s;
    logic [CW-1:0]     count_s;
    logic              full_s;
    logic              empty_s;
    logic              wr_s;
    logic              pop_s;
    logic              sa_req_s;
    logic              latch_rc_s;
    logic              latch_va_s;
    logic              clear_out_s;
    logic [N-1:0]      va_port_r;
    logic [V-1:0]      va_vc_r;
    logic [N-1:0]      out_port_r;
    logic [V-1:0]      out_vc_r;
    logic              credit_r;
    logic              overflow_r;

    assign front_type_s = front_s[FLIT_W-1 -: 2];
    assign sa_req_s     = (state_r == VC_ACTIVE) && (count_s != {CW{1'b0}}) && downCreditAvail;
    assign pop_s        = saGrant & sa_req_s;
    // A full buffer still accepts a flit when the front leaves in the same cycle.
    assign wr_s         = inValid & (~full_s | pop_s);

    flit_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (wr_s),
        .wrData (inFlit),
        .rdEn   (pop_s),
        .rdData (front_s),
        .count  (count_s),
        .full   (full_s),
        .empty  (empty_s)
    );

    // Next-state and latch-enable decode of the packet sequencer.
    always_comb begin
        next_state_s = state_r;
        latch_rc_s   = 1'b0;
        latch_va_s   = 1'b0;
        clear_out_s  = 1'b0;
        case (state_r)
            VC_IDLE: begin
                // A stray BODY/TAIL at the front is held, never popped, until reset.
                if (!empty_s && is_head(front_type_s)) begin
                    next_state_s = VC_ROUTING;
                end else begin
                    next_state_s = VC_IDLE;
                end
            end
            VC_ROUTING: begin
                latch_rc_s   = 1'b1;
                next_state_s = VC_VA;
            end
            VC_VA: begin
                if (vaGrant) begin
                    latch_va_s   = 1'b1;
                    next_state_s = VC_ACTIVE;
                end else begin
                    next_state_s = VC_VA;
                end
            end
            VC_ACTIVE: begin
                if (pop_s && is_tail(front_type_s)) begin
                    clear_out_s  = 1'b1;
                    next_state_s = VC_IDLE;
                end else begin
                    next_state_s = VC_ACTIVE;
                end
            end
            default: begin
                next_state_s = VC_IDLE;
            end
        endcase
    end

    // State, latched routing/allocation results, credit pulse and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= VC_IDLE;
            va_port_r  <= {N{1'b0}};
            va_vc_r    <= {V{1'b0}};
            out_port_r <= {N{1'b0}};
            out_vc_r   <= {V{1'b0}};
            credit_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (latch_rc_s) begin
                va_port_r <= candidateOutPort;
                va_vc_r   <= candidateOutVC;
            end
            if (latch_va_s) begin
                out_port_r <= va_port_r;
                out_vc_r   <= vaGrantVC;
            end else if (clear_out_s) begin
                out_port_r <= {N{1'b0}};
                out_vc_r   <= {V{1'b0}};
            end
            credit_r   <= pop_s;
            overflow_r <= overflow_r | (inValid & full_s & ~pop_s);
        end
    end

    assign outCredit = credit_r;
    assign overflow  = overflow_r;
    assign dst       = front_s[7:0];
    assign outFlit   = front_s;
    assign vaReq     = (state_r == VC_VA);
    assign vaReqPort = va_port_r;
    assign vaReqVC   = va_vc_r;
    assign saReq     = sa_req_s;
    assign outPort   = out_port_r;
    assign outVC     = out_vc_r;

endmodule

// File: tb/tb_input_vc_controller.sv
// Scoreboard bench: the driver pushes every accepted flit into a queue, a monitor pops and checks
// each flit the DUT releases; directed phases cover timing, overflow, reset and protocol errors.
`timescale 1ns/1ps
module tb_input_vc_controller;
    import input_vc_controller_pkg::*;

    localparam int FW = 34;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] inFlit;
    logic          inValid;
    logic          outCredit;
    logic [7:0]    dst;
    logic [N-1:0]  candidateOutPort;
    logic [V-1:0]  candidateOutVC;
    logic          vaReq;
    logic [N-1:0]  vaReqPort;
    logic [V-1:0]  vaReqVC;
    logic          vaGrant;
    logic [V-1:0]  vaGrantVC;
    logic          downCreditAvail;
    logic          saReq;
    logic          saGrant;
    logic [FW-1:0] outFlit;
    logic [N-1:0]  outPort;
    logic [V-1:0]  outVC;
    logic          overflow;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] send_q[$];
    logic [N-1:0]  cur_port = '0;
    logic [V-1:0]  cur_vc = '0;
    logic          exp_ovf = 1'b0;
    logic          pop_prev = 1'b0;

    always #5 clk = ~clk;

    input_vc_controller #(.CUR_X(0), .CUR_Y(0), .FLIT_W(FW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .inFlit(inFlit), .inValid(inValid), .outCredit(outCredit),
        .dst(dst), .candidateOutPort(candidateOutPort), .candidateOutVC(candidateOutVC),
        .vaReq(vaReq), .vaReqPort(vaReqPort), .vaReqVC(vaReqVC), .vaGrant(vaGrant),
        .vaGrantVC(vaGrantVC), .downCreditAvail(downCreditAvail), .saReq(saReq),
        .saGrant(saGrant), .outFlit(outFlit), .outPort(outPort), .outVC(outVC),
        .overflow(overflow)
    );

    // Behavioural routing unit: port = dst[2:0] mod 5 (one-hot), VC mask from dst[6:5], never empty.
    function automatic logic [N-1:0] port_of(input logic [7:0] d);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << (int'(d[2:0]) % N);
    endfunction

    function automatic logic [V-1:0] mask_of(input logic [7:0] d);
        return (d[6:5] == 2'b00) ? 2'b01 : d[6:5];
    endfunction

    always_comb begin
        candidateOutPort = port_of(dst);
        candidateOutVC   = mask_of(dst);
    end

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [7:0] d);
        logic [FW-1:0] f;
        f = {t, (FW-10)'($urandom), d};
        return f;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic bad(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected event at %0t", nm, $time);
    endtask

    task automatic idle_inputs();
        inFlit = '0; inValid = 1'b0; vaGrant = 1'b0; vaGrantVC = '0;
        downCreditAvail = 1'b0; saGrant = 1'b0;
    endtask

    task automatic put(input logic [1:0] t, input logic [7:0] d);
        logic [FW-1:0] f;
        f = mk(t, d);
        inFlit = f; inValid = 1'b1;
        exp_q.push_back(f);
    endtask

    task automatic grant_if_req(input logic allow);
        vaGrant   = vaReq & allow;
        vaGrantVC = vaReqVC[0] ? 2'b01 : 2'b10;
        if (vaGrant) cur_vc = vaGrantVC;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        idle_inputs();
        exp_q.delete();
        exp_ovf = 1'b0;
        cur_vc = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: credit latency, SA gating, VA fields and in-order flit delivery against the queue.
    initial begin : monitor
        logic [FW-1:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                pop_prev = 1'b0;
            end else begin
                chk("credit_latency", 64'(outCredit), 64'(pop_prev));
                chk("sa_without_down_credit", 64'(saReq & ~downCreditAvail), 64'(0));
                chk("overflow_flag", 64'(overflow), 64'(exp_ovf));
                if (vaReq) begin
                    if (exp_q.size() == 0) bad("va_req_no_flit");
                    else begin
                        chk("va_req_port", 64'(vaReqPort), 64'(port_of(exp_q[0][7:0])));
                        chk("va_req_vc", 64'(vaReqVC), 64'(mask_of(exp_q[0][7:0])));
                    end
                end
                pop_prev = saReq & saGrant;
                if (pop_prev) begin
                    if (exp_q.size() == 0) bad("pop_with_no_expected_flit");
                    else begin
                        e = exp_q.pop_front();
                        chk("pop_flit", 64'(outFlit), 64'(e));
                        if (is_head(e[FW-1 -: 2])) cur_port = port_of(e[7:0]);
                        chk("pop_port", 64'(outPort), 64'(cur_port));
                        chk("pop_vc", 64'(outVC), 64'(cur_vc));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, got %0d failures so far", n_err);
        $fatal(1);
    end

    initial begin : driver
        int cr;
        int len;
        logic [7:0] d;
        logic found;
        logic [FW-1:0] f;

        idle_inputs();
        rst = 1'b1;
        #12;
        chk("rst_vaReq", 64'(vaReq), 64'(0));
        chk("rst_saReq", 64'(saReq), 64'(0));
        chk("rst_outCredit", 64'(outCredit), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_outPort", 64'(outPort), 64'(0));
        chk("rst_outVC", 64'(outVC), 64'(0));
        chk("rst_vaReqPort", 64'(vaReqPort), 64'(0));
        chk("rst_vaReqVC", 64'(vaReqVC), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single HEADTAIL: route 2 cycles after write, SA right after grant, credit 1 cycle after pop.
        saGrant = 1'b1; downCreditAvail = 1'b1;
        @(negedge clk); put(HEADTAIL, 8'h12);
        @(negedge clk); inValid = 1'b0; #4 chk("t1_vaReq_w1", 64'(vaReq), 64'(0));
        @(negedge clk); #4 chk("t1_vaReq_w2", 64'(vaReq), 64'(0));
        @(negedge clk);
        vaGrant = 1'b1; vaGrantVC = 2'b01; cur_vc = 2'b01;
        #4;
        chk("t1_vaReq_rise", 64'(vaReq), 64'(1));
        chk("t1_vaReqPort", 64'(vaReqPort), 64'(5'b00100));
        chk("t1_vaReqVC", 64'(vaReqVC), 64'(2'b01));
        chk("t1_saReq_before_grant", 64'(saReq), 64'(0));
        @(negedge clk); vaGrant = 1'b0;
        #4;
        chk("t1_saReq_after_grant", 64'(saReq), 64'(1));
        chk("t1_outPort", 64'(outPort), 64'(5'b00100));
        chk("t1_outVC", 64'(outVC), 64'(2'b01));
        @(negedge clk); #4;
        chk("t1_outCredit", 64'(outCredit), 64'(1));
        chk("t1_idle_saReq", 64'(saReq), 64'(0));
        chk("t1_idle_outVC", 64'(outVC), 64'(0));
        chk("t1_idle_outPort", 64'(outPort), 64'(0));

        // Four-flit packet with downstream credit toggling every cycle.
        cr = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            downCreditAvail = (c % 2) == 1;
            inValid = 1'b0;
            if (c < 4) put((c == 0) ? HEAD : ((c == 3) ? TAIL : BODY), 8'h4B);
            #1 grant_if_req(1'b1);
            #3 cr += int'(outCredit);
        end
        chk("t2_credits", 64'(cr), 64'(4));
        chk("t2_idle_vaReq", 64'(vaReq), 64'(0));
        chk("t2_idle_outVC", 64'(outVC), 64'(0));

        // Randomized traffic under credit flow control.
        idle_inputs();
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 5);
            d = 8'($urandom);
            if (len == 1) send_q.push_back(mk(HEADTAIL, d));
            else begin
                send_q.push_back(mk(HEAD, d));
                for (int b = 0; b < len - 2; b++) send_q.push_back(mk(BODY, d));
                send_q.push_back(mk(TAIL, d));
            end
        end
        cr = DP;
        for (int c = 0; c < 4000 && (send_q.size() > 0 || exp_q.size() > 0); c++) begin
            @(negedge clk);
            cr += int'(outCredit);
            downCreditAvail = ($urandom % 4) != 0;
            inValid = 1'b0;
            if (send_q.size() > 0 && cr > 0 && ($urandom % 3) != 0) begin
                f = send_q.pop_front();
                inFlit = f; inValid = 1'b1;
                exp_q.push_back(f);
                cr--;
            end
            #1;
            grant_if_req(($urandom % 3) == 0);
            saGrant = ($urandom % 4) != 0;
        end
        chk("rnd_drained", 64'(exp_q.size() + send_q.size()), 64'(0));
        idle_inputs();
        for (int c = 0; c < 3; c++) begin @(negedge clk); cr += int'(outCredit); end
        chk("rnd_credit_balance", 64'(cr), 64'(DP));

        // Overflow: fifth write with no pop is dropped and flagged.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            put((i == 0) ? HEAD : ((i == 3) ? TAIL : BODY), 8'h21);
        end
        @(negedge clk); inFlit = mk(BODY, 8'h21); inValid = 1'b1;
        @(negedge clk); inValid = 1'b0; exp_ovf = 1'b1;
        #4 chk("t3_overflow_set", 64'(overflow), 64'(1));
        cr = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            downCreditAvail = 1'b1; saGrant = 1'b1;
            #1 grant_if_req(1'b1);
            #3 cr += int'(outCredit);
        end
        chk("t3_pops_after_drop", 64'(cr), 64'(4));
        do_reset();

        // Full buffer plus write in the same cycle as a pop is accepted.
        downCreditAvail = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            put((i == 0) ? HEAD : BODY, 8'h35);
            #1 grant_if_req(1'b1);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); inValid = 1'b0;
            #1 grant_if_req(1'b1);
            if (saReq) found = 1'b1;
        end
        chk("t3b_saReq_seen", 64'(found), 64'(1));
        put(TAIL, 8'h35); saGrant = 1'b1;
        cr = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); inValid = 1'b0;
            #4 cr += int'(outCredit);
        end
        chk("t3b_overflow_clear", 64'(overflow), 64'(0));
        chk("t3b_credits", 64'(cr), 64'(5));

        // Back-to-back packets: one IDLE cycle between tail pop and the next ROUTING.
        idle_inputs();
        saGrant = 1'b1; downCreditAvail = 1'b1;
        @(negedge clk); put(HEADTAIL, 8'h12);
        @(negedge clk); put(HEADTAIL, 8'h07);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); inValid = 1'b0;
            #1 grant_if_req(1'b1);
            if (saReq && saGrant) found = 1'b1;
        end
        chk("t4_first_pop_seen", 64'(found), 64'(1));
        @(negedge clk); vaGrant = 1'b0; #4 chk("t4_gap_idle", 64'(vaReq), 64'(0));
        @(negedge clk); #4 chk("t4_gap_routing", 64'(vaReq), 64'(0));
        @(negedge clk); #1 grant_if_req(1'b1); #3 chk("t4_second_va", 64'(vaReq), 64'(1));
        for (int c = 0; c < 10; c++) begin @(negedge clk); vaGrant = 1'b0; end
        chk("t4_drained", 64'(exp_q.size()), 64'(0));

        // Asynchronous reset while ACTIVE with three flits buffered.
        idle_inputs();
        saGrant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); put((i == 0) ? HEAD : BODY, 8'h5A);
            #1 grant_if_req(1'b1);
        end
        @(negedge clk); inValid = 1'b0; #1 grant_if_req(1'b1);
        @(negedge clk); vaGrant = 1'b0; downCreditAvail = 1'b1;
        #1 chk("t5_active_before_rst", 64'(saReq), 64'(1));
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_saReq", 64'(saReq), 64'(0));
        chk("t5_rst_vaReq", 64'(vaReq), 64'(0));
        chk("t5_rst_outCredit", 64'(outCredit), 64'(0));
        chk("t5_rst_outVC", 64'(outVC), 64'(0));
        exp_q.delete(); cur_vc = '0;
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #4;
            chk("t5_post_rst_vaReq", 64'(vaReq), 64'(0));
            chk("t5_post_rst_saReq", 64'(saReq), 64'(0));
        end

        // Stray BODY flit at the front of an idle controller is held and never routed.
        idle_inputs();
        saGrant = 1'b1; downCreditAvail = 1'b1;
        @(negedge clk); put(BODY, 8'h33);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); inValid = 1'b0;
            #1 grant_if_req(1'b1);
            #3;
            chk("t6_no_vaReq", 64'(vaReq), 64'(0));
            chk("t6_no_credit", 64'(outCredit), 64'(0));
        end
        chk("t6_body_held", 64'(exp_q.size()), 64'(1));
        do_reset();

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
